// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - IO-region decode, UART ready/valid glue, performance counters (optional MMIO_BRANCH_CNT_EN)
module mmio_io_ctrl #(
    parameter int         CNT_W     = 32,
    parameter logic [1:0] IO_REGION = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    input  logic        instr_retire,
    input  logic        branch_retire,
    input  logic        branch_taken,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready,
    output logic [31:0] io_rdata,
    output logic [31:0] cyc_counter,
    output logic [31:0] instr_counter
);
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_PEND = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              hit;
    logic [7:0]        off;
    logic              tx_wr;
    logic              cnt_clr;
    logic              tx_rdy;
    logic [0:0]        tx_state_q, tx_state_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       rd_mux;

    assign hit     = (io_addr[31:30] == IO_REGION);
    assign off     = io_addr[7:0];
    assign tx_wr   = io_we & hit & (off == 8'h08);
    assign cnt_clr = io_we & hit & (off == 8'h18);
    assign tx_rdy  = uart_tx_data_in_ready & (tx_state_q == TX_IDLE);

    assign uart_rx_data_out_ready = io_re & hit & (off == 8'h04);
    assign uart_tx_data_in        = tx_byte_q;
    assign uart_tx_data_in_valid  = (tx_state_q == TX_PEND);
    assign io_rdata               = rdata_q;
    assign cyc_counter            = 32'(cyc_q);
    assign instr_counter          = 32'(instr_q);

`ifdef MMIO_BRANCH_CNT_EN
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] tkn_q, tkn_d;

    always_comb begin
        br_d  = br_q;
        tkn_d = tkn_q;
        if (cnt_clr) begin
            br_d  = '0;
            tkn_d = '0;
        end else begin
            if (branch_retire)                br_d  = br_q + CNT_ONE;
            if (branch_retire & branch_taken) tkn_d = tkn_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_q  <= '0;
            tkn_q <= '0;
        end else begin
            br_q  <= br_d;
            tkn_q <= tkn_d;
        end
    end

    wire unused_bits = &{1'b0, io_wdata[31:8], io_addr[29:8]};
`else
    wire unused_bits = &{1'b0, io_wdata[31:8], io_addr[29:8], branch_retire, branch_taken};
`endif

    // A tx write arriving while a byte is pending is dropped, even on the handshake edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_d = TX_PEND;
                    tx_byte_d  = io_wdata[7:0];
                end
            end
            default: begin
                if (uart_tx_data_in_ready) tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_comb begin
        cyc_d   = cnt_clr ? '0 : cyc_q + CNT_ONE;
        instr_d = cnt_clr ? '0 : (instr_retire ? instr_q + CNT_ONE : instr_q);
    end

    // Counter reads see the pre-increment value of this cycle.
    always_comb begin
        rd_mux = 32'h0;
        case (off)
            8'h00:   rd_mux = {30'b0, uart_rx_data_out_valid, tx_rdy};
            8'h04:   rd_mux = {24'b0, uart_rx_data_out};
            8'h10:   rd_mux = 32'(cyc_q);
            8'h14:   rd_mux = 32'(instr_q);
`ifdef MMIO_BRANCH_CNT_EN
            8'h1C:   rd_mux = 32'(br_q);
            8'h20:   rd_mux = 32'(tkn_q);
`endif
            default: rd_mux = 32'h0;
        endcase
    end

    assign rdata_d = (io_re & hit) ? rd_mux : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_byte_q  <= 8'h00;
            cyc_q      <= '0;
            instr_q    <= '0;
            rdata_q    <= 32'h0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_byte_q  <= tx_byte_d;
            cyc_q      <= cyc_d;
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb/tb_mmio_io_ctrl.sv - scoreboard bench for mmio_io_ctrl with a transaction-level reference model
module tb_mmio_io_ctrl;
    // Narrow counters so the wrap boundary is reachable in a short run.
    localparam int CNT_W = 12;
    localparam int unsigned MASK = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr, io_wdata;
    logic        io_we, io_re, instr_retire, branch_retire, branch_taken;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid, uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid, uart_tx_data_in_ready;
    logic [31:0] io_rdata, cyc_counter, instr_counter;

    always #5 clk = ~clk;

    mmio_io_ctrl #(.CNT_W(CNT_W), .IO_REGION(2'd2)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_we(io_we), .io_re(io_re), .instr_retire(instr_retire),
        .branch_retire(branch_retire), .branch_taken(branch_taken),
        .uart_rx_data_out(uart_rx_data_out), .uart_rx_data_out_valid(uart_rx_data_out_valid),
        .uart_rx_data_out_ready(uart_rx_data_out_ready), .uart_tx_data_in(uart_tx_data_in),
        .uart_tx_data_in_valid(uart_tx_data_in_valid), .uart_tx_data_in_ready(uart_tx_data_in_ready),
        .io_rdata(io_rdata), .cyc_counter(cyc_counter), .instr_counter(instr_counter)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];

    int unsigned m_cyc, m_instr, m_br, m_tk;
    bit          m_pend;
    logic [7:0]  m_byte;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cyc = 0; m_instr = 0; m_br = 0; m_tk = 0;
        m_pend = 1'b0; m_byte = 8'h00; m_rdata = 32'h0;
        tx_q.delete();
    endtask

    task automatic drive_idle();
        io_addr = 32'h0; io_wdata = 32'h0; io_we = 1'b0; io_re = 1'b0;
        instr_retire = 1'b0; branch_retire = 1'b0; branch_taken = 1'b0;
        uart_rx_data_out = 8'h00; uart_rx_data_out_valid = 1'b0; uart_tx_data_in_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off, input bit rxv,
                                               input logic [7:0] rxd, input bit txr);
        case (off)
            8'h00: return {30'b0, rxv, txr && !m_pend};
            8'h04: return {24'b0, rxd};
            8'h10: return m_cyc;
            8'h14: return m_instr;
`ifdef MMIO_BRANCH_CNT_EN
            8'h1C: return m_br;
            8'h20: return m_tk;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive at negedge, check visible state, advance the model, cross the edge.
    task automatic step(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit rxv, input logic [7:0] rxd, input bit txr,
                        input bit ir, input bit br, input bit bt);
        bit          hit;
        bit          clr;
        logic [7:0]  off;
        logic [31:0] exp;
        io_re = re; io_we = we; io_addr = addr; io_wdata = wdata;
        uart_rx_data_out_valid = rxv; uart_rx_data_out = rxd; uart_tx_data_in_ready = txr;
        instr_retire = ir; branch_retire = br; branch_taken = bt;
        #1;
        hit = (addr[31:30] == 2'b10);
        off = addr[7:0];
        chk("rx_ready", {31'b0, uart_rx_data_out_ready}, {31'b0, re && hit && off == 8'h04});
        chk("tx_valid", {31'b0, uart_tx_data_in_valid}, {31'b0, m_pend});
        if (m_pend) chk("tx_byte_hold", {24'b0, uart_tx_data_in}, {24'b0, m_byte});
        chk("cyc_counter", cyc_counter, m_cyc);
        chk("instr_counter", instr_counter, m_instr);
        chk("io_rdata_hold", io_rdata, m_rdata);
        if (re && hit) begin
            exp = model_read(off, rxv, rxd, txr);
            rd_q.push_back(exp);
            m_rdata = exp;
        end
        if (m_pend) begin
            if (txr) m_pend = 1'b0;
        end else if (we && hit && off == 8'h08) begin
            m_pend = 1'b1;
            m_byte = wdata[7:0];
            tx_q.push_back(m_byte);
        end
        clr = we && hit && off == 8'h18;
        m_cyc   = clr ? 0 : (m_cyc + 1) & MASK;
        m_instr = clr ? 0 : (m_instr + (ir ? 1 : 0)) & MASK;
        m_br    = clr ? 0 : (m_br + (br ? 1 : 0)) & MASK;
        m_tk    = clr ? 0 : (m_tk + ((br && bt) ? 1 : 0)) & MASK;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit txr);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, 8'h00, txr, 0, 0, 0);
    endtask

    // Monitor: every load response and every tx handshake is matched against the scoreboard.
    initial begin
        bit         ld, hs;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            ld = !rst && io_re && io_addr[31:30] == 2'b10;
            hs = !rst && uart_tx_data_in_valid && uart_tx_data_in_ready;
            b  = uart_tx_data_in;
            #1;
            if (ld) begin
                if (rd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL io_rdata_sb: unexpected load response 0x%08h", io_rdata);
                end else chk("io_rdata", io_rdata, rd_q.pop_front());
            end
            if (hs) begin
                if (tx_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL tx_sb: unexpected tx byte 0x%02h", b);
                end else chk("tx_byte_out", {24'b0, b}, {24'b0, tx_q.pop_front()});
            end
        end
    end

    logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h40, 8'h0C};

    task automatic random_steps(input int n);
        bit          re, we;
        int          sel;
        logic [1:0]  reg_sel;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 3);
            re  = (sel == 1);
            we  = (sel == 2);
            reg_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            addr = {reg_sel, 22'($urandom), offs[$urandom_range(0, 9)]};
            // Keep counter clears rare so counters accumulate.
            if (we && addr[7:0] == 8'h18 && $urandom_range(0, 3) != 0) addr[7:0] = 8'h08;
            step(re, we, addr, $urandom, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        do_reset();
        chk("reset_cyc", cyc_counter, 32'h0);
        chk("reset_rdata", io_rdata, 32'h0);
        chk("reset_tx_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);

        idle(5, 0);
        chk("cyc_after_5", cyc_counter, 32'd5);

        step(1, 0, 32'h8000_0004, 32'h0, 1, 8'h5A, 0, 0, 0, 0);
        chk("rx_byte", io_rdata, 32'h0000_005A);

        step(0, 1, 32'h8000_0008, 32'h41, 0, 8'h00, 0, 0, 0, 0);
        step(0, 1, 32'h8000_0008, 32'h42, 0, 8'h00, 0, 0, 0, 0);
        step(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 0, 0, 0);
        chk("tx_byte_kept", {24'b0, uart_tx_data_in}, 32'h41);
        chk("tx_valid_pend", {31'b0, uart_tx_data_in_valid}, 32'h1);
        chk("status_tx_busy", io_rdata, 32'h0);
        step(0, 1, 32'h8000_0008, 32'h43, 0, 8'h00, 1, 0, 0, 0);
        chk("tx_valid_drop", {31'b0, uart_tx_data_in_valid}, 32'h0);

        step(1, 0, 32'h8000_0040, 32'h0, 0, 8'h00, 0, 0, 0, 0);
        chk("unmapped_read", io_rdata, 32'h0);

        step(0, 1, 32'h8000_0018, 32'h0, 0, 8'h00, 0, 1, 0, 0);
        chk("clr_instr", instr_counter, 32'h0);
        chk("clr_cyc", cyc_counter, 32'h0);

        step(0, 0, 32'h0, 32'h0, 0, 8'h00, 0, 1, 1, 1);
        step(0, 0, 32'h0, 32'h0, 0, 8'h00, 0, 1, 1, 0);
        step(0, 0, 32'h0, 32'h0, 0, 8'h00, 0, 1, 1, 1);
        step(1, 0, 32'h8000_001C, 32'h0, 0, 8'h00, 0, 0, 0, 0);
`ifdef MMIO_BRANCH_CNT_EN
        chk("branch_cnt", io_rdata, 32'd3);
`else
        chk("branch_cnt", io_rdata, 32'd0);
`endif
        step(1, 0, 32'h8000_0020, 32'h0, 0, 8'h00, 0, 0, 0, 0);
`ifdef MMIO_BRANCH_CNT_EN
        chk("taken_cnt", io_rdata, 32'd2);
`else
        chk("taken_cnt", io_rdata, 32'd0);
`endif

        step(0, 1, 32'h8000_0018, 32'h0, 0, 8'h00, 0, 0, 0, 0);
        idle(MASK, 0);
        chk("cyc_max", cyc_counter, MASK);
        step(1, 0, 32'h8000_0010, 32'h0, 0, 8'h00, 0, 0, 0, 0);
        chk("cyc_wrap", cyc_counter, 32'h0);
        chk("cyc_read_prewrap", io_rdata, MASK);

        random_steps(1500);

        step(0, 1, 32'h8000_0008, 32'h77, 0, 8'h00, 0, 0, 0, 0);
        do_reset();
        chk("reset_drops_pend", {31'b0, uart_tx_data_in_valid}, 32'h0);

        random_steps(1500);
        idle(4, 1);
        chk("rd_q_drained", rd_q.size(), 32'h0);
        chk("tx_q_drained", tx_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
